// File: rtl/branch_pht.sv
// rtl/branch_pht.sv - gshare pattern history table with 2-bit saturating counters
// Walks the table to INIT_COUNTER after reset, then predicts and trains on resolved branches.
module branch_pht #(
    parameter int         INDEX_WIDTH  = 10,
    parameter logic [1:0] INIT_COUNTER = 2'b01
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            fetch_pc,
    output logic [INDEX_WIDTH-1:0] pred_index,
    output logic [1:0]             pred_counter,
    output logic                   pred_taken,
    output logic                   ready,
    input  logic                   update_valid,
    input  logic [INDEX_WIDTH-1:0] update_index,
    input  logic                   update_taken
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] init_ptr;
    logic [INDEX_WIDTH-1:0] ghr;
    logic [1:0]             table_mem [ENTRIES];
    logic [1:0]             upd_cur;
    logic [1:0]             upd_next;
    logic [INDEX_WIDTH-1:0] ghr_eff;
    logic                   active;

    // PC bit 0 and the upper bits do not participate in the index.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, fetch_pc[15:INDEX_WIDTH+1], fetch_pc[0]};

    // Reset masks history and prediction combinationally so the reset cycle itself looks like INIT.
    assign active       = (state == READY) && !reset;
    assign ghr_eff      = reset ? '0 : ghr;
    assign pred_index   = fetch_pc[INDEX_WIDTH:1] ^ ghr_eff;
    assign pred_counter = active ? table_mem[pred_index] : INIT_COUNTER;
    assign pred_taken   = pred_counter[1];
    assign ready        = active;

    // Training re-reads the table rather than trusting the value carried down the pipe.
    always_comb begin
        upd_cur  = table_mem[update_index];
        upd_next = upd_cur;
        if (update_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_ptr <= '0;
            ghr      <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == {INDEX_WIDTH{1'b1}}) state <= READY;
                end
                READY: begin
                    if (update_valid) ghr <= {ghr[INDEX_WIDTH-2:0], update_taken};
                end
                default: state <= INIT;
            endcase
        end
    end

    // Table kept reset-free so it can map onto RAM; the INIT walk provides its initial contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                table_mem[init_ptr] <= INIT_COUNTER;
            end else if (update_valid) begin
                table_mem[update_index] <= upd_next;
            end
        end
    end
endmodule

// File: tb/tb_branch_pht.sv
// tb/tb_branch_pht.sv - directed self-checking bench for branch_pht
module tb_branch_pht;
    localparam int IW = 10;
    localparam int N  = 1 << IW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   fetch_pc = 16'h0014;
    logic [IW-1:0] pred_index;
    logic [1:0]    pred_counter;
    logic          pred_taken;
    logic          ready;
    logic          update_valid = 1'b0;
    logic [IW-1:0] update_index = '0;
    logic          update_taken = 1'b0;

    int            errors = 0;
    int            checks = 0;
    logic [IW-1:0] ghr_m = '0;

    branch_pht #(.INDEX_WIDTH(IW), .INIT_COUNTER(2'b01)) dut (
        .clk(clk),
        .reset(reset),
        .fetch_pc(fetch_pc),
        .pred_index(pred_index),
        .pred_counter(pred_counter),
        .pred_taken(pred_taken),
        .ready(ready),
        .update_valid(update_valid),
        .update_index(update_index),
        .update_taken(update_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        update_valid = 1'b0;
        fetch_pc = 16'h0014;
        #1;
        check({tag, "_rst_ready"}, 32'(ready), 0);
        check({tag, "_rst_cnt"}, 32'(pred_counter), 1);
        check({tag, "_rst_taken"}, 32'(pred_taken), 0);
        check({tag, "_rst_index"}, 32'(pred_index), 32'h00A);
        tick();
        reset = 1'b0;
        ghr_m = '0;
        #1;
        check({tag, "_post_ready"}, 32'(ready), 0);
        check({tag, "_post_cnt"}, 32'(pred_counter), 1);
        check({tag, "_post_index"}, 32'(pred_index), 32'h00A);
    endtask

    // Counts the INIT cycles, optionally pulsing update_valid, and expects ready exactly after N cycles.
    task automatic wait_init(input string tag, input bit pulse);
        int early = 0;
        for (int i = 0; i < N; i++) begin
            if (ready !== 1'b0) early++;
            update_valid = pulse && ((i >= 600 && i < 610) || i == N - 1 || (i >= 3 && i < 8));
            update_index = IW'(i);
            update_taken = (i % 3) != 0;
            tick();
        end
        update_valid = 1'b0;
        check({tag, "_early_ready"}, 32'(early), 0);
        check({tag, "_ready"}, 32'(ready), 1);
    endtask

    task automatic sweep(input string tag);
        int bad = 0;
        logic [IW-1:0] ix;
        for (int i = 0; i < N; i++) begin
            ix = IW'(i);
            fetch_pc = {5'b0, ix, 1'b0};
            #1;
            if (pred_counter !== 2'b01) bad++;
            if (pred_index !== (ix ^ ghr_m)) bad++;
        end
        check({tag, "_sweep_bad"}, 32'(bad), 0);
    endtask

    task automatic read_entry(input string tag, input logic [IW-1:0] idx, input logic [1:0] exp);
        logic [IW-1:0] aim;
        aim = idx ^ ghr_m;
        fetch_pc = {5'b0, aim, 1'b0};
        #1;
        check({tag, "_cnt"}, 32'(pred_counter), 32'(exp));
        check({tag, "_taken"}, 32'(pred_taken), 32'(exp[1]));
    endtask

    task automatic do_update(input logic [IW-1:0] idx, input logic taken);
        update_valid = 1'b1;
        update_index = idx;
        update_taken = taken;
        tick();
        update_valid = 1'b0;
        ghr_m = {ghr_m[IW-2:0], taken};
    endtask

    initial begin
        // 1: reset, init length, all entries weakly not-taken
        pulse_reset("t1");
        wait_init("t1", 1'b0);
        sweep("t1");

        // 2: taken training on entry 5 saturates at 11
        do_update(10'd5, 1'b1);
        read_entry("t2_u1", 10'd5, 2'b10);
        do_update(10'd5, 1'b1);
        read_entry("t2_u2", 10'd5, 2'b11);
        do_update(10'd5, 1'b1);
        read_entry("t2_u3", 10'd5, 2'b11);

        // 3: not-taken training on entry 7 saturates at 00
        do_update(10'd7, 1'b0);
        read_entry("t3_u1", 10'd7, 2'b00);
        do_update(10'd7, 1'b0);
        do_update(10'd7, 1'b0);
        read_entry("t3_u3", 10'd7, 2'b00);
        read_entry("t3_untouched", 10'd6, 2'b01);

        // 7: read and update of the same entry in one cycle returns the old value
        fetch_pc = {5'b0, (10'd3 ^ ghr_m), 1'b0};
        update_valid = 1'b1;
        update_index = 10'd3;
        update_taken = 1'b1;
        #1;
        check("t7_same_cycle", 32'(pred_counter), 1);
        tick();
        update_valid = 1'b0;
        ghr_m = {ghr_m[IW-2:0], 1'b1};
        read_entry("t7_next", 10'd3, 2'b10);

        // 4: reset from READY, then history T,N,T gives ghr = 5
        pulse_reset("t4");
        wait_init("t4", 1'b0);
        do_update(10'd20, 1'b1);
        do_update(10'd21, 1'b0);
        do_update(10'd22, 1'b1);
        fetch_pc = 16'h0010;
        #1;
        check("t4_ghr_index", 32'(pred_index), 32'h00D);
        // back-to-back updates to the same entry both apply
        do_update(10'd9, 1'b1);
        do_update(10'd9, 1'b1);
        read_entry("t4_b2b", 10'd9, 2'b11);

        // 5/6: updates during INIT ignored, reset mid-INIT restarts the walk
        pulse_reset("t5");
        for (int c = 0; c < 500; c++) begin
            update_valid = (c >= 100 && c < 110);
            update_index = IW'(c);
            update_taken = 1'b1;
            tick();
        end
        check("t6_mid_ready", 32'(ready), 0);
        pulse_reset("t6");
        wait_init("t6", 1'b1);
        fetch_pc = 16'h0010;
        #1;
        check("t5_ghr_zero", 32'(pred_index), 32'h008);
        sweep("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
